// File: rtl/nop_tag_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : nop_tag_pipeline
// Purpose  : NOP flag + sideband tag delay line with run-time latency tap,
//            stall, synchronous flush and in-flight occupancy count.
// Revision : 1.0  initial release
// ============================================================================
module nop_tag_pipeline #(
  parameter int TagWidth  = 8,
  parameter int MaxStages = 16,
  parameter int LatW      = 5,
  parameter int CntW      = 5
) (
  input  logic                clk,
  input  logic                aclr,
  input  logic                en,
  input  logic                flush,
  input  logic [LatW-1:0]     lat_sel,
  input  logic                NOPIn,
  input  logic [TagWidth-1:0] TagIn,
  output logic                NOPOut,
  output logic [TagWidth-1:0] TagOut,
  output logic [CntW-1:0]     inflight,
  output logic                drained
);

  logic [MaxStages-1:0]               nop_q, nop_d;
  logic [MaxStages-1:0][TagWidth-1:0] tag_q, tag_d;
  logic [LatW-1:0]                    tap_idx;
  logic [CntW-1:0]                    cnt;

  always_comb begin
    nop_d = nop_q;
    tag_d = tag_q;
    if (flush) begin
      nop_d = '1;
      tag_d = '0;
    end else if (en) begin
      nop_d = {nop_q[MaxStages-2:0], NOPIn};
      // Bubbles always enter with a zero tag so downstream never sees stale tags.
      tag_d = {tag_q[MaxStages-2:0], (NOPIn ? {TagWidth{1'b0}} : TagIn)};
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      nop_q <= '1;
      tag_q <= '0;
    end else begin
      nop_q <= nop_d;
      tag_q <= tag_d;
    end
  end

  // Tap index is L-1, with lat_sel clamped into 1..MaxStages.
  always_comb begin
    if (lat_sel == '0)
      tap_idx = '0;
    else if (lat_sel > LatW'(MaxStages))
      tap_idx = LatW'(MaxStages - 1);
    else
      tap_idx = lat_sel - LatW'(1);
  end

  always_comb begin
    NOPOut = 1'b1;
    TagOut = '0;
    cnt    = '0;
    for (int i = 0; i < MaxStages; i++) begin
      if (LatW'(i) == tap_idx) begin
        NOPOut = nop_q[i];
        TagOut = tag_q[i];
      end
      if ((LatW'(i) <= tap_idx) && !nop_q[i])
        cnt = cnt + CntW'(1);
    end
  end

  assign inflight = cnt;
  assign drained  = (cnt == '0);

endmodule
`default_nettype wire

// File: doc/nop_tag_pipeline.md
Name: nop_tag_pipeline

Overview:
Parametrised successor to the fixed 7-stage NOP flag delay line. It carries a NOP flag plus a TagWidth-bit sideband tag alongside the multiply/add datapath. The tap latency is selectable at run time, and the block adds stall, synchronous flush and in-flight occupancy reporting. It sits beside each convolution MAC lane, so that the output tag and NOP flag line up with the arithmetic result for any configured pipeline depth.

Parameters:
TagWidth, 8, width of the sideband tag carried with each entry
MaxStages, 16, number of physical stages; must be >= 2
LatW, 5, width of lat_sel; must satisfy 2^LatW > MaxStages
CntW, 5, width of inflight; must satisfy 2^CntW > MaxStages

Ports:
clk  input  1  rising-edge clock
aclr  input  1  asynchronous active-high reset
en  input  1  advance enable; 0 = stall, all stages hold
flush  input  1  synchronous flush; marks every stage NOP
lat_sel  input  LatW  requested latency in cycles (clamped, see below)
NOPIn  input  1  1 = bubble entering, 0 = valid entry
TagIn  input  TagWidth  tag for the entering entry
NOPOut  output  1  NOP flag at the selected tap
TagOut  output  TagWidth  tag at the selected tap
inflight  output  CntW  count of valid entries in stages 0..L-1
drained  output  1  1 when inflight == 0

Behaviour:
- Storage: nop_r[0..MaxStages-1] (1 bit each) and tag_r[0..MaxStages-1] (TagWidth bits each).
- aclr=1, asynchronous: every nop_r = 1, every tag_r = 0. Outputs then read NOPOut=1, TagOut=0, inflight=0, drained=1. Reset asserted mid-stream discards all entries immediately.
- Effective latency L = 1 if lat_sel == 0; MaxStages if lat_sel > MaxStages; otherwise lat_sel.
- Clock edge priority, highest first: flush > en > hold.
  - flush=1: all nop_r <= 1 and all tag_r <= 0, regardless of en. NOPIn/TagIn that cycle are dropped.
  - en=1, flush=0: nop_r[0] <= NOPIn. tag_r[0] <= NOPIn ? 0 : TagIn, so bubbles always carry tag 0. Stage i+1 <= stage i for i = 0..MaxStages-2. Stage MaxStages-1 content is discarded.
  - en=0, flush=0: all stages hold. NOPIn/TagIn ignored.
- Outputs: NOPOut = nop_r[L-1] and TagOut = tag_r[L-1], taken combinationally from registers.
  - An entry presented with en=1 appears at the outputs after exactly L enabled edges.
  - Stalled cycles add no latency count.
- lat_sel change: retargets the tap in the same cycle, with no state change.
  - Raising L can re-expose entries still in the deeper stages.
  - Lowering L can hide entries already past the new tap.
  - Both are legal. Control must change lat_sel only while drained=1 if it needs exactly-once delivery.
- inflight = popcount of (nop_r[i] == 0) for i = 0..L-1, combinational. Range 0..MaxStages. drained = (inflight == 0).
- Default configuration MaxStages >= 7 with lat_sel = 7 is cycle-identical to the legacy 7-stage NOP line when en=1 and flush=0.
- No handshake back-pressure: upstream must stall in step with the datapath via the shared en.

Test Plan:
- Reset: assert aclr mid-stream with 3 valid entries in flight -> same cycle NOPOut=1, TagOut=0, inflight=0, drained=1. Hold 1 after release with NOPIn=1.
- Latency sweep: lat_sel = 1, 7, 16. Single valid entry NOPIn=0, TagIn=8'hA5, with en=1 -> NOPOut=0, TagOut=8'hA5 exactly 1/7/16 edges later, for one cycle only. lat_sel = 0 behaves as 1; lat_sel = 20 behaves as 16.
- Stall: lat_sel=7, inject tag 8'h3C, then drop en for 4 cycles after edge 3 -> output appears at cycle 11, and inflight stays 1 throughout the stall.
- Flush: lat_sel=7, 5 back-to-back tags 1..5, flush at cycle 4 with en=1 -> next cycle inflight=0, drained=1. No tags 1..5 ever reach the output. A tag injected the cycle after flush emerges normally 7 edges later.
- Bubble tag masking: NOPIn=1 with TagIn=8'hFF -> NOPOut=1 with TagOut=0 after L edges. Alternating valid/NOP stream at lat_sel=4 gives inflight = 2 in steady state.
- Latency retarget: lat_sel=8, tag 8'h11 at stage 5 -> switch lat_sel to 4: inflight=0 and the entry is never output. Switch back to 8 before it leaves stage 7: it emerges at the original cycle.
